// File: rtl/aes_round_ctrl_if.sv
// Handshake, ciphertext and round-datapath/key-scheduler bundle for aes_round_ctrl.
// slave is the controller's view; master is the view of the block driving and consuming it.
interface aes_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [127:0] dp_state;
    logic [127:0] dp_shift;
    logic [127:0] dp_mix;
    logic [3:0]   ks_round;
    logic [127:0] ks_key;
    logic [127:0] ks_key_out;
    logic [3:0]   round;
    logic         busy;

    modport slave (
        input  in_valid, in_data, key_in, out_ready, dp_shift, dp_mix, ks_key_out,
        output in_ready, out_valid, out_data, dp_state, ks_round, ks_key, round, busy
    );

    modport master (
        output in_valid, in_data, key_in, out_ready, dp_shift, dp_mix, ks_key_out,
        input  in_ready, out_valid, out_data, dp_state, ks_round, ks_key, round, busy
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: out_valid rises NUM_ROUNDS*ROUND_CYCLES edges after acceptance;
// input stalls (in_ready=0) outside IDLE, ciphertext held in DONE until out_ready.
module aes_round_ctrl #(
    parameter int ROUND_CYCLES = 2,
    parameter int NUM_ROUNDS   = 10
) (
    input  logic            clk,
    input  logic            rst,
    aes_round_ctrl_if.slave bus
);

    if (ROUND_CYCLES < 1 || ROUND_CYCLES > 15) begin : g_bad_round_cycles
        $error("aes_round_ctrl: ROUND_CYCLES must be within 1..15");
    end
    if (NUM_ROUNDS != 10) begin : g_bad_num_rounds
        $error("aes_round_ctrl: NUM_ROUNDS is fixed at 10 for AES-128");
    end

    localparam logic [3:0] LP_LAST_CYC = 4'(ROUND_CYCLES - 1);
    localparam logic [3:0] LP_LAST_RND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    fsm_t         r_fsm;
    logic [127:0] r_state;
    logic [127:0] r_rk;
    logic [3:0]   r_round;
    logic [3:0]   r_cyc;
    logic         r_out_valid;
    logic         r_busy;

    logic         w_in_ready;
    logic         w_accept;
    logic         w_round_end;
    logic         w_final_round;
    logic [127:0] w_round_res;

    // in_ready also gated by rst so a block offered during reset is never taken.
    assign w_in_ready    = (r_fsm == IDLE) && !rst;
    assign w_accept      = bus.in_valid && w_in_ready;
    assign w_round_end   = (r_cyc == LP_LAST_CYC);
    assign w_final_round = (r_round == LP_LAST_RND);
    // The last round has no MixColumns step.
    assign w_round_res   = (w_final_round ? bus.dp_shift : bus.dp_mix) ^ bus.ks_key_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_rk        <= '0;
            r_round     <= '0;
            r_cyc       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= bus.in_data ^ bus.key_in;
                        r_rk    <= bus.key_in;
                        r_round <= 4'd1;
                        r_cyc   <= '0;
                        r_busy  <= 1'b1;
                        r_fsm   <= ROUND;
                    end
                end
                ROUND: begin
                    if (w_round_end) begin
                        r_state <= w_round_res;
                        r_rk    <= bus.ks_key_out;
                        r_cyc   <= '0;
                        if (w_final_round) begin
                            r_round     <= '0;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_fsm       <= DONE;
                        end else begin
                            r_round <= r_round + 4'd1;
                        end
                    end else begin
                        r_cyc <= r_cyc + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_fsm       <= IDLE;
                    end
                end
                default: begin
                    r_fsm       <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_valid ? r_state : '0;
    assign bus.dp_state  = r_state;
    assign bus.ks_key    = r_rk;
    assign bus.ks_round  = r_round;
    assign bus.round     = r_round;
    assign bus.busy      = r_busy;

    a_round_bound: assert property (@(posedge clk) disable iff (rst) r_round <= LP_LAST_RND);
    a_cyc_bound: assert property (@(posedge clk) disable iff (rst) r_cyc <= LP_LAST_CYC);
    a_out_hold: assert property (@(posedge clk) disable iff (rst)
        (r_out_valid && !bus.out_ready) |=> (r_out_valid && $stable(r_state)));

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;
    localparam int RC0 = 2;
    localparam int RC1 = 1;

    logic clk;
    logic rst;
    int   edge_cnt = 0;
    int   checks   = 0;
    int   failures = 0;

    aes_round_ctrl_if if0 ();
    aes_round_ctrl_if if1 ();

    aes_round_ctrl #(.ROUND_CYCLES(RC0), .NUM_ROUNDS(10)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    aes_round_ctrl #(.ROUND_CYCLES(RC1), .NUM_ROUNDS(10)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- AES arithmetic (byte i lives at bits [8i+7:8i]) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p, r;
        p = x; r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(r+4*c) +: 8] = sbox(s[8*(r+4*((c+r)%4)) +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(4*c)   +: 8]; a1 = s[8*(4*c+1) +: 8];
            a2 = s[8*(4*c+2) +: 8]; a3 = s[8*(4*c+3) +: 8];
            o[8*(4*c)   +: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[8*(4*c+1) +: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[8*(4*c+2) +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[8*(4*c+3) +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input int rnd);
        logic [7:0]   rc;
        logic [31:0]  t;
        logic [127:0] n;
        rc = 8'h01;
        for (int i = 1; i < rnd; i++) rc = gmul(rc, 8'h02);
        t = {sbox(k[8*12 +: 8]), sbox(k[8*15 +: 8]), sbox(k[8*14 +: 8]), sbox(k[8*13 +: 8]) ^ rc};
        n[31:0]   = k[31:0]   ^ t;
        n[63:32]  = k[63:32]  ^ n[31:0];
        n[95:64]  = k[95:64]  ^ n[63:32];
        n[127:96] = k[127:96] ^ n[95:64];
        return n;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s, k;
        s = pt ^ key; k = key;
        for (int r = 1; r <= 10; r++) begin
            k = key_next(k, r);
            s = ((r == 10) ? sub_shift(s) : mix(sub_shift(s))) ^ k;
        end
        return s;
    endfunction

    // FIPS-197 listings are byte 0 first (MSB of the hex literal).
    function automatic logic [127:0] fv(input logic [127:0] h);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = h[8*(15-i) +: 8];
        return o;
    endfunction

    // Round datapath and key scheduler attached to each controller.
    always_comb begin
        if0.dp_shift   = sub_shift(if0.dp_state);
        if0.dp_mix     = mix(if0.dp_shift);
        if0.ks_key_out = key_next(if0.ks_key, int'(if0.ks_round));
        if1.dp_shift   = sub_shift(if1.dp_state);
        if1.dp_mix     = mix(if1.dp_shift);
        if1.ks_key_out = key_next(if1.ks_key, int'(if1.ks_round));
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        failures++;
        $display("FAIL timeout %s: awaited event never occurred", name);
    endtask

    typedef struct {
        logic [127:0] data;
        int           acc;
    } exp_t;

    exp_t         q[2][$];
    exp_t         cur[2];
    bit           prev_ov[2];
    int           acc_edge[2];
    int           rise_edge[2];
    logic [127:0] last_out[2];

    task automatic mon(input int d, input logic iv, input logic ir, input logic ov,
                       input logic [127:0] od, input logic [127:0] ind, input logic [127:0] key);
        exp_t e;
        if (rst) begin
            q[d].delete();
            prev_ov[d] = 1'b0;
            return;
        end
        if (iv && ir) begin
            e.data = aes_ref(ind, key);
            e.acc  = edge_cnt + 1;
            acc_edge[d] = e.acc;
            q[d].push_back(e);
        end
        if (ov && !prev_ov[d]) begin
            rise_edge[d] = edge_cnt;
            if (q[d].size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out dut%0d: out_valid rose with no block in flight", d);
            end else begin
                cur[d] = q[d].pop_front();
                chk($sformatf("latency_dut%0d", d), 128'(edge_cnt - cur[d].acc),
                    128'(10 * (d == 0 ? RC0 : RC1)));
            end
        end
        if (ov) begin
            chk($sformatf("out_data_dut%0d", d), od, cur[d].data);
            last_out[d] = od;
        end else begin
            chk($sformatf("out_data_idle_dut%0d", d), od, '0);
        end
        prev_ov[d] = ov;
    endtask

    always @(negedge clk) mon(0, if0.in_valid, if0.in_ready, if0.out_valid, if0.out_data, if0.in_data, if0.key_in);
    always @(negedge clk) mon(1, if1.in_valid, if1.in_ready, if1.out_valid, if1.out_data, if1.in_data, if1.key_in);

    // ---------------- stimulus helpers (dut0) ----------------
    task automatic wait_acc0(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (if0.in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) tmo(name);
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
    endtask

    task automatic send0(input logic [127:0] pt, input logic [127:0] key, input string name);
        @(posedge clk); #1;
        if0.in_valid = 1'b1;
        if0.in_data  = pt;
        if0.key_in   = key;
        wait_acc0(name);
    endtask

    task automatic drain0(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (q[0].size() == 0 && !if0.out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) tmo(name);
    endtask

    task automatic wait_round0(input logic [3:0] r, input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (if0.round == r) begin ok = 1'b1; break; end
        end
        if (!ok) tmo(name);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] kb, pb, cb, kc, pc, cc, pt, key, exp;
    bit           rand_done;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        kb = fv(128'h2b7e151628aed2a6abf7158809cf4f3c);
        pb = fv(128'h3243f6a8885a308d313198a2e0370734);
        cb = fv(128'h3925841d02dc09fbdc118597196a0b32);
        kc = fv(128'h000102030405060708090a0b0c0d0e0f);
        pc = fv(128'h00112233445566778899aabbccddeeff);
        cc = fv(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        rst = 1'b1;
        if0.in_valid = 1'b0; if0.in_data = '0; if0.key_in = '0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.in_data = '0; if1.key_in = '0; if1.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(if0.in_ready), 128'(0));
        chk("rst_out_valid", 128'(if0.out_valid), 128'(0));
        chk("rst_busy", 128'(if0.busy), 128'(0));
        chk("rst_round", 128'(if0.round), 128'(0));
        chk("rst_out_data", if0.out_data, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(if0.in_ready), 128'(1));
        chk("post_rst_in_ready_dut1", 128'(if1.in_ready), 128'(1));

        // App. B with round stepping
        if0.out_ready = 1'b1;
        send0(pb, kb, "accept_appb");
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk("round_step", 128'(if0.round), 128'(j / 2 + 1));
            chk("busy_in_round", 128'(if0.busy), 128'(1));
            chk("in_ready_in_round", 128'(if0.in_ready), 128'(0));
        end
        drain0("drain_appb");
        chk("appb_cipher", last_out[0], cb);

        // App. C.1 then a back-to-back block
        send0(pc, kc, "accept_appc");
        if0.in_valid = 1'b1;
        if0.in_data  = rnd128();
        if0.key_in   = rnd128();
        wait_acc0("accept_b2b");
        chk("appc_cipher", last_out[0], cc);
        chk("b2b_gap", 128'(acc_edge[0] - rise_edge[0]), 128'(2));
        drain0("drain_b2b");

        // Backpressure for 7 cycles with in_valid pulses
        @(posedge clk); #1;
        if0.out_ready = 1'b0;
        pt = rnd128(); key = rnd128(); exp = aes_ref(pt, key);
        send0(pt, key, "accept_bp");
        begin
            bit ok;
            ok = 1'b0;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (if0.out_valid) begin ok = 1'b1; break; end
            end
            if (!ok) tmo("bp_out_valid");
        end
        for (int i = 0; i < 7; i++) begin
            chk("bp_out_valid", 128'(if0.out_valid), 128'(1));
            chk("bp_out_data", if0.out_data, exp);
            chk("bp_in_ready", 128'(if0.in_ready), 128'(0));
            @(posedge clk); #1;
            if0.in_valid = (i % 2 == 0);
            if0.in_data  = rnd128();
            @(negedge clk);
        end
        @(posedge clk); #1;
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 128'(if0.out_valid), 128'(1));
        @(negedge clk);
        chk("bp_idle_valid", 128'(if0.out_valid), 128'(0));
        chk("bp_idle_in_ready", 128'(if0.in_ready), 128'(1));

        // Busy rejection: second block held during rounds 3..6
        send0(pb, kb, "accept_busy_a");
        wait_round0(4'd3, "reach_round3");
        @(posedge clk); #1;
        if0.in_valid = 1'b1;
        if0.in_data  = pc;
        if0.key_in   = kc;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (if0.round < 4'd3 || if0.round > 4'd6) break;
            chk("busy_reject_in_ready", 128'(if0.in_ready), 128'(0));
        end
        wait_acc0("accept_busy_b");
        chk("busy_b_after_done", 128'(acc_edge[0] - rise_edge[0]), 128'(2));
        chk("busy_a_cipher", last_out[0], cb);
        drain0("drain_busy");
        chk("busy_b_cipher", last_out[0], cc);

        // Reset in round 5
        send0(rnd128(), rnd128(), "accept_rst");
        wait_round0(4'd5, "reach_round5");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_round", 128'(if0.round), 128'(0));
        chk("midrst_in_ready", 128'(if0.in_ready), 128'(1));
        chk("midrst_out_valid", 128'(if0.out_valid), 128'(0));
        chk("midrst_busy", 128'(if0.busy), 128'(0));
        repeat (30) @(negedge clk);
        send0(pb, kb, "accept_after_rst");
        drain0("drain_after_rst");
        chk("after_rst_cipher", last_out[0], cb);

        // Randomized traffic with random consumer stalls
        rand_done = 1'b0;
        fork
            begin
                for (int b = 0; b < 40; b++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send0(rnd128(), rnd128(), "accept_rand");
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    if0.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        @(posedge clk); #1;
        if0.out_ready = 1'b1;
        drain0("drain_rand");

        // ROUND_CYCLES=1 instance with App. B
        @(posedge clk); #1;
        if1.in_valid = 1'b1;
        if1.in_data  = pb;
        if1.key_in   = kb;
        begin
            bit ok;
            ok = 1'b0;
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (if1.in_ready) begin ok = 1'b1; break; end
            end
            if (!ok) tmo("accept_rc1");
            @(posedge clk); #1;
            if1.in_valid = 1'b0;
            ok = 1'b0;
            for (int n = 0; n < 200; n++) begin
                @(negedge clk);
                if (q[1].size() == 0 && !if1.out_valid) begin ok = 1'b1; break; end
            end
            if (!ok) tmo("drain_rc1");
        end
        chk("rc1_cipher", last_out[1], cb);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
